// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and downstream-side handshake bundle for the RISC-V decode stage.
// The master modport is the fetch/consumer side; the slave modport is the stage.
interface riscv_decode_stage_if #(
    parameter int unsigned XLEN               = 32,
    parameter int unsigned INSTRUCTION_LENGTH = 32,
    parameter int unsigned TYPE_WIDTH         = 3,
    parameter int unsigned REGISTER_WIDTH     = 5,
    parameter int unsigned FLAG_WIDTH         = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [INSTRUCTION_LENGTH-1:0] in_instruction;
    logic [XLEN-1:0]               in_pc;

    logic                          out_valid;
    logic                          out_ready;
    logic [TYPE_WIDTH-1:0]         out_type;
    logic [REGISTER_WIDTH-1:0]     out_rd;
    logic [REGISTER_WIDTH-1:0]     out_rs1;
    logic [REGISTER_WIDTH-1:0]     out_rs2;
    logic [XLEN-1:0]               out_imm;
    logic [FLAG_WIDTH-1:0]         out_flag;
    logic [XLEN-1:0]               out_pc;
    logic [INSTRUCTION_LENGTH-1:0] out_instruction;

    modport master (
        output in_valid, in_instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
        input  out_imm, out_flag, out_pc, out_instruction
    );

    modport slave (
        input  in_valid, in_instruction, in_pc, out_ready,
        output in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
        output out_imm, out_flag, out_pc, out_instruction
    );
endinterface

// File: rtl/riscv_decode_stage.sv
// RISC-V base-ISA decode stage: opcode classification, register/immediate extraction
// and a 2-entry output queue with valid/ready on both sides.
module riscv_decode_stage #(
    parameter int unsigned XLEN               = 32,
    parameter int unsigned INSTRUCTION_LENGTH = 32,
    parameter int unsigned TYPE_WIDTH         = 3,
    parameter int unsigned REGISTER_WIDTH     = 5,
    parameter int unsigned FLAG_WIDTH         = 8,
    parameter int unsigned COUNT_WIDTH        = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    riscv_decode_stage_if.slave    bus,
    output logic [COUNT_WIDTH-1:0] decode_count
);
    // Type codes as defined in instruction_types.defs; 0 marks an illegal opcode.
    localparam logic [2:0] R_TYPE  = 3'd1;
    localparam logic [2:0] I_TYPE  = 3'd2;
    localparam logic [2:0] S_TYPE  = 3'd3;
    localparam logic [2:0] SB_TYPE = 3'd4;
    localparam logic [2:0] U_TYPE  = 3'd5;
    localparam logic [2:0] UJ_TYPE = 3'd6;

    logic [31:0]               w_ins;
    logic [2:0]                w_type;
    logic [7:0]                w_flag;
    logic [31:0]               w_imm32;
    logic [XLEN-1:0]           w_imm;
    logic [REGISTER_WIDTH-1:0] w_rd;
    logic [REGISTER_WIDTH-1:0] w_rs1;
    logic [REGISTER_WIDTH-1:0] w_rs2;
    logic                      w_push;
    logic                      w_pop;

    logic [TYPE_WIDTH-1:0]         r_type  [2];
    logic [REGISTER_WIDTH-1:0]     r_rd    [2];
    logic [REGISTER_WIDTH-1:0]     r_rs1   [2];
    logic [REGISTER_WIDTH-1:0]     r_rs2   [2];
    logic [XLEN-1:0]               r_imm   [2];
    logic [FLAG_WIDTH-1:0]         r_flag  [2];
    logic [XLEN-1:0]               r_pc    [2];
    logic [INSTRUCTION_LENGTH-1:0] r_instr [2];
    logic                          r_wptr;
    logic                          r_rptr;
    logic [1:0]                    r_count;
    logic [COUNT_WIDTH-1:0]        r_decode_count;

    assign w_ins = 32'(bus.in_instruction);

    always_comb begin
        w_type  = 3'd0;
        w_flag  = 8'h10;
        w_imm32 = 32'd0;
        case (w_ins[6:0])
            7'b0110011, 7'b0111011: begin
                w_type = R_TYPE;
                w_flag = 8'h07;
            end
            7'b0010011, 7'b0011011, 7'b1110011, 7'b0001111: begin
                w_type  = I_TYPE;
                w_flag  = 8'h0B;
                w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            7'b0000011: begin
                w_type  = I_TYPE;
                w_flag  = 8'h8B;
                w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            7'b1100111: begin
                w_type  = I_TYPE;
                w_flag  = 8'h4B;
                w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            7'b0100011: begin
                w_type  = S_TYPE;
                w_flag  = 8'h8E;
                w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            end
            7'b1100011: begin
                w_type  = SB_TYPE;
                w_flag  = 8'h2E;
                w_imm32 = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_type  = U_TYPE;
                w_flag  = 8'h09;
                w_imm32 = {w_ins[31:12], 12'd0};
            end
            7'b1101111: begin
                w_type  = UJ_TYPE;
                w_flag  = 8'h49;
                w_imm32 = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Signed cast widens with sign extension to XLEN.
    assign w_imm = XLEN'($signed(w_imm32));
    assign w_rd  = w_flag[0] ? REGISTER_WIDTH'(w_ins[11:7])  : '0;
    assign w_rs1 = w_flag[1] ? REGISTER_WIDTH'(w_ins[19:15]) : '0;
    assign w_rs2 = w_flag[2] ? REGISTER_WIDTH'(w_ins[24:20]) : '0;

    assign bus.in_ready  = (r_count != 2'd2) && !flush;
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_type[i]  <= '0;
                r_rd[i]    <= '0;
                r_rs1[i]   <= '0;
                r_rs2[i]   <= '0;
                r_imm[i]   <= '0;
                r_flag[i]  <= '0;
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_type[r_wptr]  <= TYPE_WIDTH'(w_type);
                r_rd[r_wptr]    <= w_rd;
                r_rs1[r_wptr]   <= w_rs1;
                r_rs2[r_wptr]   <= w_rs2;
                r_imm[r_wptr]   <= w_imm;
                r_flag[r_wptr]  <= FLAG_WIDTH'(w_flag);
                r_pc[r_wptr]    <= bus.in_pc;
                r_instr[r_wptr] <= bus.in_instruction;
                r_wptr          <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Counts every output handshake, including one coinciding with a flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_decode_count <= '0;
        end else if (w_pop) begin
            r_decode_count <= r_decode_count + 1'b1;
        end
    end

    assign decode_count        = r_decode_count;
    assign bus.out_type        = r_type[r_rptr];
    assign bus.out_rd          = r_rd[r_rptr];
    assign bus.out_rs1         = r_rs1[r_rptr];
    assign bus.out_rs2         = r_rs2[r_rptr];
    assign bus.out_imm         = r_imm[r_rptr];
    assign bus.out_flag        = r_flag[r_rptr];
    assign bus.out_pc          = r_pc[r_rptr];
    assign bus.out_instruction = r_instr[r_rptr];
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed scoreboard bench for riscv_decode_stage at XLEN = 64: expected records are
// queued when an instruction is offered and checked when the head is handshaked out.
module tb_riscv_decode_stage;
    localparam int unsigned XLEN = 64;
    localparam logic [2:0] T_ILL = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3;
    localparam logic [2:0] T_SB = 3'd4, T_U = 3'd5, T_UJ = 3'd6;

    typedef struct packed {
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [7:0]  flag;
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] decode_count;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   base;

    riscv_decode_stage_if #(.XLEN(XLEN)) bus ();

    riscv_decode_stage #(.XLEN(XLEN)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .bus          (bus),
        .decode_count (decode_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_rec(input logic [2:0] typ, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [63:0] imm,
                              input logic [7:0] flag, input logic [63:0] pc,
                              input logic [31:0] ins);
        exp_t e;
        e.typ = typ; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.flag = flag; e.pc = pc; e.ins = ins;
        q.push_back(e);
    endtask

    // Offer one word and hold it until the stage accepts it (bounded).
    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        bit ok = 1'b0;
        bus.in_valid       = 1'b1;
        bus.in_instruction = ins;
        bus.in_pc          = pc;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
        @(negedge clk);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
        chk("drain_decode_count", 64'(decode_count), 64'(exp_cnt));
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'(bus.out_instruction), 64'hdead);
            end else begin
                m_e = q.pop_front();
                chk("type", 64'(bus.out_type), 64'(m_e.typ));
                chk("rd", 64'(bus.out_rd), 64'(m_e.rd));
                chk("rs1", 64'(bus.out_rs1), 64'(m_e.rs1));
                chk("rs2", 64'(bus.out_rs2), 64'(m_e.rs2));
                chk("imm", bus.out_imm, m_e.imm);
                chk("flag", 64'(bus.out_flag), 64'(m_e.flag));
                chk("pc", bus.out_pc, m_e.pc);
                chk("instruction", 64'(bus.out_instruction), 64'(m_e.ins));
            end
            exp_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid       = 1'b0;
        bus.in_instruction = '0;
        bus.in_pc          = '0;
        bus.out_ready      = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_decode_count", 64'(decode_count), 64'd0);
        chk("rst_out_imm", bus.out_imm, 64'd0);
        chk("rst_out_type", 64'(bus.out_type), 64'd0);
        chk("rst_out_flag", 64'(bus.out_flag), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // addi x1,x2,-1, then one-cycle latency check
        expect_rec(T_I, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0B, 64'h100, 32'hFFF10093);
        send(32'hFFF10093, 64'h100);
        chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
        drain();
        chk("first_decode_count", 64'(decode_count), 64'd1);

        // Back-to-back stream at full throughput
        @(posedge clk);
        #1;
        expect_rec(T_S, 5'd0, 5'd6, 5'd5, 64'd8, 8'h8E, 64'h104, 32'h00532423);
        expect_rec(T_SB, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 8'h2E, 64'h108, 32'hFE000EE3);
        expect_rec(T_U, 5'd5, 5'd0, 5'd0, 64'h0000_0000_1234_5000, 8'h09, 64'h10C, 32'h123452B7);
        expect_rec(T_UJ, 5'd0, 5'd0, 5'd0, 64'd0, 8'h49, 64'h110, 32'h0000006F);
        expect_rec(T_ILL, 5'd0, 5'd0, 5'd0, 64'd0, 8'h10, 64'h114, 32'h00000000);
        expect_rec(T_R, 5'd3, 5'd1, 5'd2, 64'd0, 8'h07, 64'h118, 32'h002081B3);
        expect_rec(T_I, 5'd5, 5'd6, 5'd0, 64'd4, 8'h8B, 64'h11C, 32'h00432283);
        expect_rec(T_I, 5'd1, 5'd2, 5'd0, 64'd0, 8'h4B, 64'h120, 32'h000100E7);
        expect_rec(T_U, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000, 8'h09, 64'h124, 32'h800000B7);
        expect_rec(T_ILL, 5'd0, 5'd0, 5'd0, 64'd0, 8'h10, 64'h128, 32'h00000010);
        send(32'h00532423, 64'h104);
        send(32'hFE000EE3, 64'h108);
        send(32'h123452B7, 64'h10C);
        send(32'h0000006F, 64'h110);
        send(32'h00000000, 64'h114);
        send(32'h002081B3, 64'h118);
        send(32'h00432283, 64'h11C);
        send(32'h000100E7, 64'h120);
        send(32'h800000B7, 64'h124);
        send(32'h00000010, 64'h128);
        drain();

        // Backpressure: fill both entries, third waits for the first pop
        @(posedge clk);
        #1;
        base = exp_cnt;
        bus.out_ready = 1'b0;
        expect_rec(T_R, 5'd3, 5'd1, 5'd2, 64'd0, 8'h07, 64'h200, 32'h002081B3);
        expect_rec(T_S, 5'd0, 5'd6, 5'd5, 64'd8, 8'h8E, 64'h204, 32'h00532423);
        expect_rec(T_I, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0B, 64'h208, 32'hFFF10093);
        send(32'h002081B3, 64'h200);
        send(32'h00532423, 64'h204);
        bus.in_valid       = 1'b1;
        bus.in_instruction = 32'hFFF10093;
        bus.in_pc          = 64'h208;
        @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_head_pc", bus.out_pc, 64'h200);
        @(posedge clk);
        #1;
        chk("full_hold_pc", bus.out_pc, 64'h200);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        chk("bp_decode_count", 64'(decode_count), 64'(base + 3));

        // Flush with two entries buffered and a word on offer
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        expect_rec(T_R, 5'd3, 5'd1, 5'd2, 64'd0, 8'h07, 64'h300, 32'h002081B3);
        expect_rec(T_R, 5'd3, 5'd1, 5'd2, 64'd0, 8'h07, 64'h304, 32'h002081B3);
        send(32'h002081B3, 64'h300);
        send(32'h002081B3, 64'h304);
        base               = exp_cnt;
        flush              = 1'b1;
        bus.in_valid       = 1'b1;
        bus.in_instruction = 32'h0000006F;
        bus.in_pc          = 64'h308;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("flush_decode_count", 64'(decode_count), 64'(base));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        expect_rec(T_S, 5'd0, 5'd6, 5'd5, 64'd8, 8'h8E, 64'h30C, 32'h00532423);
        send(32'h00532423, 64'h30C);
        drain();

        // Asynchronous reset mid-stream
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(32'hFFF10093, 64'h400);
        send(32'h123452B7, 64'h404);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_decode_count", 64'(decode_count), 64'd0);
        chk("arst_out_imm", bus.out_imm, 64'd0);
        chk("arst_out_pc", bus.out_pc, 64'd0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        expect_rec(T_UJ, 5'd0, 5'd0, 5'd0, 64'd0, 8'h49, 64'h500, 32'h0000006F);
        send(32'h0000006F, 64'h500);
        drain();
        chk("post_reset_decode_count", 64'(decode_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
